fft_bitrev_reorder: RTL and testbench

//  Output reorder buffer directly downstream of the FFT stage chain.

---
 rtl/fft_bitrev_reorder.sv | 107 ++++++++++
 tb/tb_fft_bitrev_reorder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: accepts FFT output frames in bit-reversed bin order
// and streams them out in natural order on a valid/ready interface.
package fft_pkg;
  parameter int DATA_WIDTH = 16;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } complex_t;
endpackage

module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int LOG2_N = 3
) (
  input  logic     clk,
  input  logic     rst,
  input  complex_t s_data,
  input  logic     s_valid,
  output logic     s_ready,
  input  logic     s_last,
  output complex_t m_data,
  output logic     m_valid,
  input  logic     m_ready,
  output logic     m_last,
  output logic     err
);

  localparam int N = 1 << LOG2_N;
  localparam logic [LOG2_N-1:0] LAST_IDX = '1;

  logic [LOG2_N-1:0] wcnt;
  logic [LOG2_N-1:0] rcnt;
  logic              wbank;
  logic              rbank;
  logic [1:0]        full;
  logic              wr_fire;
  logic              rd_fire;

  complex_t mem [2][N];

  function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] a);
    logic [LOG2_N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG2_N; i++) begin
      r[i] = a[LOG2_N-1-i];
    end
    return r;
  endfunction

  assign s_ready = !full[wbank];
  assign wr_fire = s_valid && s_ready;
  assign rd_fire = full[rbank] && (!m_valid || m_ready);

  // Bank storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wbank][bitrev(wcnt)] <= s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt    <= '0;
      wbank   <= 1'b0;
      rcnt    <= '0;
      rbank   <= 1'b0;
      full    <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= wr_fire && (s_last != (wcnt == LAST_IDX));

      if (wr_fire) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == LAST_IDX) begin
          wbank <= ~wbank;
        end
      end

      if (rd_fire) begin
        m_data  <= mem[rbank][rcnt];
        m_valid <= 1'b1;
        m_last  <= (rcnt == LAST_IDX);
        rcnt    <= rcnt + 1'b1;
        if (rcnt == LAST_IDX) begin
          rbank <= ~rbank;
        end
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end

      // Set and clear always target different banks, so both updates land.
      if (wr_fire && (wcnt == LAST_IDX)) begin
        full[wbank] <= 1'b1;
      end
      if (rd_fire && (rcnt == LAST_IDX)) begin
        full[rbank] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder (N=8): source/expected queues driven
// from hand-written bit-reversed frames, outputs checked in natural order.
module tb_fft_bitrev_reorder;
  import fft_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  complex_t s_data;
  logic     s_valid;
  logic     s_ready;
  logic     s_last;
  complex_t m_data;
  logic     m_valid;
  logic     m_ready;
  logic     m_last;
  logic     err;

  fft_bitrev_reorder #(.LOG2_N(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_last (s_last),
    .m_data (m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last (m_last),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    complex_t d;
    logic     l;
  } beat_t;

  beat_t    src_q[$];
  beat_t    exp_q[$];
  int       n_checks = 0;
  int       n_fail   = 0;
  int       acc_cnt;
  int       out_cnt;
  int       err_cnt;
  int       gaps;
  logic     out_started;
  logic     stall_prev;
  complex_t held_data;
  logic     held_last;
  int       rdy_mode;  // 0: hold m_ready low, 1: high, 2: random
  int unsigned ord[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic complex_t mk(input int unsigned v);
    complex_t c;
    c.re = 16'(v);
    c.im = 16'(v + 32'h0100);
    return c;
  endfunction

  // Beat i carries bin ord[i]; bad_pos additionally raises s_last on that beat.
  task automatic push_frame(input int unsigned base, input int bad_pos);
    beat_t b;
    for (int i = 0; i < 8; i++) begin
      b.d = mk(base + ord[i]);
      b.l = (i == 7) || (i == bad_pos);
      src_q.push_back(b);
    end
    for (int k = 0; k < 8; k++) begin
      b.d = mk(base + 32'(k));
      b.l = (k == 7);
      exp_q.push_back(b);
    end
  endtask

  task automatic clear_counts();
    acc_cnt = 0; out_cnt = 0; err_cnt = 0; gaps = 0; out_started = 1'b0;
  endtask

  task automatic tick();
    beat_t e;
    s_valid = (src_q.size() > 0);
    s_data  = s_valid ? src_q[0].d : '0;
    s_last  = s_valid ? src_q[0].l : 1'b0;
    m_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    @(negedge clk);
    if (stall_prev) begin
      check("hold_data", m_data, held_data);
      check("hold_last", {31'b0, m_last}, {31'b0, held_last});
    end
    if (m_valid) out_started = 1'b1;
    else if (out_started && exp_q.size() > 0 && rdy_mode == 1) gaps++;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_out", {31'b0, m_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("data", m_data, e.d);
        check("last", {31'b0, m_last}, {31'b0, e.l});
      end
      out_cnt++;
    end
    stall_prev = m_valid && !m_ready;
    held_data  = m_data;
    held_last  = m_last;
    if (s_valid && s_ready) begin
      void'(src_q.pop_front());
      acc_cnt++;
    end
    if (err) err_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int cyc;
    rdy_mode = (rdy_mode == 0) ? 1 : rdy_mode;
    cyc = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0 || m_valid) && cyc < 2000) begin
      tick();
      cyc++;
    end
    if (cyc >= 2000) check("drain_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    src_q.delete();
    exp_q.delete();
    stall_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    m_ready  = 1'b1;
    rdy_mode = 1;
    clear_counts();
    do_reset();
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_m_last",  {31'b0, m_last},  32'd0);
    check("rst_m_data",  m_data,           32'd0);
    check("rst_err",     {31'b0, err},     32'd0);
    check("rst_s_ready", {31'b0, s_ready}, 32'd1);

    // 1: single frame, latency of one edge after the last accept
    clear_counts();
    push_frame(0, -1);
    for (int i = 0; i < 20 && acc_cnt < 8; i++) tick();
    check("t1_accepts", 32'(acc_cnt), 32'd8);
    check("t1_valid_t", {31'b0, m_valid}, 32'd0);
    tick();
    check("t1_valid_t1", {31'b0, m_valid}, 32'd1);
    check("t1_bin0", m_data, mk(0));
    drain();
    check("t1_outputs", 32'(out_cnt), 32'd8);
    check("t1_err", 32'(err_cnt), 32'd0);

    // 2: downstream blocked, three frames offered
    clear_counts();
    rdy_mode = 0;
    push_frame(32'h10, -1);
    push_frame(32'h20, -1);
    push_frame(32'h30, -1);
    repeat (30) tick();
    check("t2_accepts", 32'(acc_cnt), 32'd16);
    check("t2_s_ready", {31'b0, s_ready}, 32'd0);
    check("t2_m_valid", {31'b0, m_valid}, 32'd1);
    check("t2_head", m_data, mk(32'h10));
    check("t2_pending", 32'(src_q.size()), 32'd8);
    rdy_mode = 1;
    drain();
    check("t2_outputs", 32'(out_cnt), 32'd24);

    // 3: four frames back-to-back, no output bubbles
    clear_counts();
    for (int f = 0; f < 4; f++) push_frame(32'h40 + 32'(f) * 16, -1);
    drain();
    check("t3_outputs", 32'(out_cnt), 32'd32);
    check("t3_gaps", 32'(gaps), 32'd0);

    // 4: random backpressure
    clear_counts();
    rdy_mode = 2;
    for (int f = 0; f < 3; f++) push_frame(32'h80 + 32'(f) * 16, -1);
    drain();
    check("t4_outputs", 32'(out_cnt), 32'd24);
    rdy_mode = 1;

    // 5: early s_last on beat 5
    clear_counts();
    push_frame(32'hC0, 5);
    drain();
    check("t5_err_cycles", 32'(err_cnt), 32'd1);
    check("t5_outputs", 32'(out_cnt), 32'd8);

    // 6: reset after three accepts of a frame
    clear_counts();
    push_frame(32'hD0, -1);
    for (int i = 0; i < 10 && acc_cnt < 3; i++) tick();
    check("t6_partial", 32'(acc_cnt), 32'd3);
    do_reset();
    clear_counts();
    repeat (12) tick();
    check("t6_no_out", 32'(out_cnt), 32'd0);
    check("t6_m_valid", {31'b0, m_valid}, 32'd0);
    check("t6_s_ready", {31'b0, s_ready}, 32'd1);
    push_frame(32'hE0, -1);
    drain();
    check("t6_outputs", 32'(out_cnt), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
